par2ser_stream: RTL and testbench

//   Parameterised parallel-to-serial converter with a valid/ready load handshake,

---
 rtl/par2ser_stream.sv | 130 +++++++++++++
 tb/tb_par2ser_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/par2ser_stream.sv
// Purpose : parallel-to-serial converter; one WORD_LENGTH-bit word per par_valid/par_ready
//           handshake, shifted out one bit per clk with ser_valid/ser_last framing.
// Latency : first bit on ser the cycle after the accept edge; back-to-back words have no gap.
// Backpressure: par_ready is high in IDLE and on the last-bit cycle only; par is sampled on accept.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous abort of the in-flight word (wins over a same-cycle accept)
//   par_valid  producer has a word on par
//   par        parallel word
//   par_ready  block can take a word this cycle (combinational)
//   ser        serial data (registered), IDLE_LEVEL when idle
//   ser_valid  ser carries a data bit (registered)
//   ser_last   ser carries the final bit of a word (registered)
//   busy       word in progress, same as ser_valid
module par2ser_stream #(
    parameter int WORD_LENGTH = 8,
    parameter bit LSB_FIRST   = 1'b0,
    parameter bit IDLE_LEVEL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   par_valid,
    input  logic [WORD_LENGTH-1:0] par,
    output logic                   par_ready,
    output logic                   ser,
    output logic                   ser_valid,
    output logic                   ser_last,
    output logic                   busy
);

    localparam int CW = $clog2(WORD_LENGTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    // Bits still to send after the one currently on ser.
    logic [CW-1:0]          cnt;
    // Remaining bits, aligned so the next bit to send sits at the outgoing end.
    logic [WORD_LENGTH-1:0] sreg;
    logic                   accept;

    // A flush in the same cycle blocks the handshake, so the offered word stays with the producer.
    assign accept = par_valid & par_ready & ~flush;
    assign busy   = ser_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = SHIFT;
                SHIFT:   if ((cnt == '0) && !accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: ready in IDLE, or on the last bit so the next word follows without a gap.
    always_comb begin
        par_ready = 1'b0;
        case (state)
            IDLE:    par_ready = 1'b1;
            SHIFT:   par_ready = (cnt == '0);
            default: par_ready = 1'b0;
        endcase
    end

    // Serial datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser       <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
        end else if (flush) begin
            ser       <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
        end else if (accept) begin
            if (LSB_FIRST) begin
                ser  <= par[0];
                sreg <= par >> 1;
            end else begin
                ser  <= par[WORD_LENGTH-1];
                sreg <= par << 1;
            end
            ser_valid <= 1'b1;
            // WORD_LENGTH >= 2, so the first bit is never the last.
            ser_last  <= 1'b0;
            cnt       <= CW'(WORD_LENGTH - 1);
        end else if ((state == SHIFT) && (cnt != '0)) begin
            if (LSB_FIRST) begin
                ser  <= sreg[0];
                sreg <= sreg >> 1;
            end else begin
                ser  <= sreg[WORD_LENGTH-1];
                sreg <= sreg << 1;
            end
            ser_last <= (cnt == CW'(1));
            cnt      <= cnt - CW'(1);
        end else if (state == SHIFT) begin
            // Last bit done and no new word: return to idle levels.
            ser       <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_par2ser_stream.sv
module tb_par2ser_stream;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       par_valid;
    logic [7:0] par;

    logic par_ready_m, ser_m, ser_valid_m, ser_last_m, busy_m;
    logic par_ready_l, ser_l, ser_valid_l, ser_last_l, busy_l;

    int n_cmp;
    int n_err;

    // Reference model: bits of the word in flight, front element is the bit currently on ser.
    bit qm[$];
    bit ql[$];

    par2ser_stream #(.WORD_LENGTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .reset(rst), .flush(flush), .par_valid(par_valid), .par(par),
        .par_ready(par_ready_m), .ser(ser_m), .ser_valid(ser_valid_m),
        .ser_last(ser_last_m), .busy(busy_m)
    );

    par2ser_stream #(.WORD_LENGTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .reset(rst), .flush(flush), .par_valid(par_valid), .par(par),
        .par_ready(par_ready_l), .ser(ser_l), .ser_valid(ser_valid_l),
        .ser_last(ser_last_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("ser_m",  ser_m,       (qm.size() > 0) ? qm[0] : 1'b0);
        chk("vld_m",  ser_valid_m, qm.size() > 0);
        chk("last_m", ser_last_m,  qm.size() == 1);
        chk("busy_m", busy_m,      qm.size() > 0);
        chk("ser_l",  ser_l,       (ql.size() > 0) ? ql[0] : 1'b1);
        chk("vld_l",  ser_valid_l, ql.size() > 0);
        chk("last_l", ser_last_l,  ql.size() == 1);
        chk("busy_l", busy_l,      ql.size() > 0);
    endtask

    // Model edge: flush drops everything; otherwise the current bit leaves and an accepted
    // word contributes its bits in transmit order.
    task automatic model_edge(input bit acc, input bit fl, input logic [7:0] w);
        if (fl) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back(w[7-i]);
                    ql.push_back(w[i]);
                end
            end
        end
    endtask

    // One clock cycle: check ready before the edge, update model on the edge, check after.
    task automatic tick();
        bit         acc;
        bit         exp_rdy;
        logic [7:0] w;
        #1;
        exp_rdy = (qm.size() <= 1);
        chk("ready_m", par_ready_m, exp_rdy);
        chk("ready_l", par_ready_l, ql.size() <= 1);
        acc = par_valid && exp_rdy && !flush;
        w   = par;
        @(posedge clk);
        model_edge(acc, flush, w);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] cap_m;
        logic [7:0] cap_l;
        int         nvld;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        par_valid = 1'b0;
        par       = 8'h00;

        // Reset state
        #2;
        check_outputs();
        chk("rst_ready_m", par_ready_m, 1'b1);
        chk("rst_ready_l", par_ready_l, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single word 0xA5, MSB first
        par       = 8'hA5;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        cap_m     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cap_m = {cap_m[6:0], ser_m};
            if (i < 7) tick();
        end
        chk("a5_bits", cap_m, 8'hA5);
        tick();
        chk("a5_idle", ser_valid_m, 1'b0);

        // Back-to-back 0xA5, 0x3C with par_valid held
        par       = 8'hA5;
        par_valid = 1'b1;
        tick();
        par  = 8'h3C;
        nvld = 0;
        for (int i = 0; i < 16; i++) begin
            if (ser_valid_m) nvld++;
            tick();
            if (i == 7) par_valid = 1'b0;
        end
        chk("stream_vld_cycles", nvld, 16);
        chk("stream_end_idle", ser_valid_m, 1'b0);

        // 0x01 with par changing mid-word; LSB-first instance sends 1 first
        par       = 8'h01;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        cap_m     = 8'h00;
        cap_l     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cap_m = {cap_m[6:0], ser_m};
            cap_l = {ser_l, cap_l[7:1]};
            if (i == 0) chk("lsb_first_bit", ser_l, 1'b1);
            par = 8'($urandom);
            if (i < 7) tick();
        end
        chk("lsb_word", cap_l, 8'h01);
        chk("msb_word", cap_m, 8'h01);
        tick();

        // Flush on the 3rd bit of 0xFF with par_valid held
        par       = 8'hFF;
        par_valid = 1'b1;
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        chk("flush_ser", ser_m, 1'b0);
        chk("flush_vld", ser_valid_m, 1'b0);
        flush = 1'b0;
        tick();
        chk("flush_restart_vld", ser_valid_m, 1'b1);
        chk("flush_restart_bit7", ser_m, 1'b1);
        par_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset mid-word, then a fresh word
        par       = 8'hC3;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        qm.delete();
        ql.delete();
        check_outputs();
        chk("async_vld", ser_valid_m, 1'b0);
        #1;
        rst       = 1'b0;
        par       = 8'h5A;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        cap_m     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cap_m = {cap_m[6:0], ser_m};
            if (i < 7) tick();
        end
        chk("post_reset_word", cap_m, 8'h5A);
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            par_valid = ($urandom_range(0, 3) != 0);
            par       = 8'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        par_valid = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
